// File: rtl/ahbl_arbiter.sv
// rtl/ahbl_arbiter.sv - N:1 fixed-priority AHB-lite arbiter; losing address phases are parked per master.
module ahbl_arbiter #(
  parameter int N_PORTS = 2,
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_PORTS-1:0]          src_hready,
  output logic [N_PORTS-1:0]          src_hready_resp,
  output logic [N_PORTS-1:0]          src_hresp,
  input  logic [N_PORTS*W_ADDR-1:0]   src_haddr,
  input  logic [N_PORTS-1:0]          src_hwrite,
  input  logic [N_PORTS*2-1:0]        src_htrans,
  input  logic [N_PORTS*3-1:0]        src_hsize,
  input  logic [N_PORTS*3-1:0]        src_hburst,
  input  logic [N_PORTS*4-1:0]        src_hprot,
  input  logic [N_PORTS-1:0]          src_hmastlock,
  input  logic [N_PORTS*W_DATA-1:0]   src_hwdata,
  output logic [N_PORTS*W_DATA-1:0]   src_hrdata,
  output logic                        dst_hready,
  input  logic                        dst_hready_resp,
  input  logic                        dst_hresp,
  output logic [W_ADDR-1:0]           dst_haddr,
  output logic                        dst_hwrite,
  output logic [1:0]                  dst_htrans,
  output logic [2:0]                  dst_hsize,
  output logic [2:0]                  dst_hburst,
  output logic [3:0]                  dst_hprot,
  output logic                        dst_hmastlock,
  output logic [W_DATA-1:0]           dst_hwdata,
  input  logic [W_DATA-1:0]           dst_hrdata
);

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  logic [N_PORTS-1:0] live;
  logic [N_PORTS-1:0] req;
  logic [N_PORTS-1:0] gnt_a;
  logic               found;

  logic [N_PORTS-1:0] buf_valid_q, buf_valid_d;
  logic [N_PORTS-1:0] gnt_d_q, gnt_d_d;

  logic [W_ADDR-1:0]  buf_haddr_q     [N_PORTS];
  logic [W_ADDR-1:0]  buf_haddr_d     [N_PORTS];
  logic               buf_hwrite_q    [N_PORTS];
  logic               buf_hwrite_d    [N_PORTS];
  logic [1:0]         buf_htrans_q    [N_PORTS];
  logic [1:0]         buf_htrans_d    [N_PORTS];
  logic [2:0]         buf_hsize_q     [N_PORTS];
  logic [2:0]         buf_hsize_d     [N_PORTS];
  logic [2:0]         buf_hburst_q    [N_PORTS];
  logic [2:0]         buf_hburst_d    [N_PORTS];
  logic [3:0]         buf_hprot_q     [N_PORTS];
  logic [3:0]         buf_hprot_d     [N_PORTS];
  logic               buf_hmastlock_q [N_PORTS];
  logic               buf_hmastlock_d [N_PORTS];

  // Lowest index with a parked or live request owns the address phase.
  always_comb begin
    live  = '0;
    req   = '0;
    gnt_a = '0;
    found = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      live[i] = (src_htrans[2*i +: 2] != HTRANS_IDLE) && src_hready[i];
      req[i]  = buf_valid_q[i] | live[i];
      if (req[i] && !found) begin
        gnt_a[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    dst_haddr     = '0;
    dst_hwrite    = 1'b0;
    dst_htrans    = HTRANS_IDLE;
    dst_hsize     = '0;
    dst_hburst    = '0;
    dst_hprot     = '0;
    dst_hmastlock = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (gnt_a[i]) begin
        if (buf_valid_q[i]) begin
          dst_haddr     = buf_haddr_q[i];
          dst_hwrite    = buf_hwrite_q[i];
          dst_htrans    = buf_htrans_q[i];
          dst_hsize     = buf_hsize_q[i];
          dst_hburst    = buf_hburst_q[i];
          dst_hprot     = buf_hprot_q[i];
          dst_hmastlock = buf_hmastlock_q[i];
        end else begin
          dst_haddr     = src_haddr[W_ADDR*i +: W_ADDR];
          dst_hwrite    = src_hwrite[i];
          dst_htrans    = src_htrans[2*i +: 2];
          dst_hsize     = src_hsize[3*i +: 3];
          dst_hburst    = src_hburst[3*i +: 3];
          dst_hprot     = src_hprot[4*i +: 4];
          dst_hmastlock = src_hmastlock[i];
        end
      end
    end
  end

  always_comb begin
    buf_valid_d     = buf_valid_q;
    gnt_d_d         = gnt_d_q;
    buf_haddr_d     = buf_haddr_q;
    buf_hwrite_d    = buf_hwrite_q;
    buf_htrans_d    = buf_htrans_q;
    buf_hsize_d     = buf_hsize_q;
    buf_hburst_d    = buf_hburst_q;
    buf_hprot_d     = buf_hprot_q;
    buf_hmastlock_d = buf_hmastlock_q;
    if (dst_hready_resp) begin
      gnt_d_d     = gnt_a;
      buf_valid_d = buf_valid_q & ~gnt_a;
    end
    // A live request not accepted downstream this edge is parked; its data phase starts now.
    for (int i = 0; i < N_PORTS; i++) begin
      if (live[i] && !buf_valid_q[i] && (!gnt_a[i] || !dst_hready_resp)) begin
        buf_valid_d[i]     = 1'b1;
        buf_haddr_d[i]     = src_haddr[W_ADDR*i +: W_ADDR];
        buf_hwrite_d[i]    = src_hwrite[i];
        buf_htrans_d[i]    = src_htrans[2*i +: 2];
        buf_hsize_d[i]     = src_hsize[3*i +: 3];
        buf_hburst_d[i]    = src_hburst[3*i +: 3];
        buf_hprot_d[i]     = src_hprot[4*i +: 4];
        buf_hmastlock_d[i] = src_hmastlock[i];
      end
    end
  end

  always_comb begin
    src_hready_resp = '0;
    src_hresp       = '0;
    dst_hwdata      = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      src_hready_resp[i] = gnt_d_q[i] ? dst_hready_resp : !buf_valid_q[i];
      src_hresp[i]       = gnt_d_q[i] & dst_hresp;
      if (gnt_d_q[i]) begin
        dst_hwdata = src_hwdata[W_DATA*i +: W_DATA];
      end
    end
  end

  assign dst_hready = dst_hready_resp;
  assign src_hrdata = {N_PORTS{dst_hrdata}};

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid_q <= '0;
      gnt_d_q     <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      gnt_d_q     <= gnt_d_d;
    end
  end

  // Payload needs no reset: it is only observed while buf_valid_q is set.
  always_ff @(posedge clk) begin
    buf_haddr_q     <= buf_haddr_d;
    buf_hwrite_q    <= buf_hwrite_d;
    buf_htrans_q    <= buf_htrans_d;
    buf_hsize_q     <= buf_hsize_d;
    buf_hburst_q    <= buf_hburst_d;
    buf_hprot_q     <= buf_hprot_d;
    buf_hmastlock_q <= buf_hmastlock_d;
  end

endmodule

// File: tb/tb_ahbl_arbiter.sv
// tb/tb_ahbl_arbiter.sv - directed bench for ahbl_arbiter with two masters.
module tb_ahbl_arbiter;

  localparam int N  = 2;
  localparam int WA = 32;
  localparam int WD = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      src_hready;
  logic [N-1:0]      src_hready_resp;
  logic [N-1:0]      src_hresp;
  logic [N*WA-1:0]   src_haddr;
  logic [N-1:0]      src_hwrite;
  logic [N*2-1:0]    src_htrans;
  logic [N*3-1:0]    src_hsize;
  logic [N*3-1:0]    src_hburst;
  logic [N*4-1:0]    src_hprot;
  logic [N-1:0]      src_hmastlock;
  logic [N*WD-1:0]   src_hwdata;
  logic [N*WD-1:0]   src_hrdata;
  logic              dst_hready;
  logic              dst_hready_resp;
  logic              dst_hresp;
  logic [WA-1:0]     dst_haddr;
  logic              dst_hwrite;
  logic [1:0]        dst_htrans;
  logic [2:0]        dst_hsize;
  logic [2:0]        dst_hburst;
  logic [3:0]        dst_hprot;
  logic              dst_hmastlock;
  logic [WD-1:0]     dst_hwdata;
  logic [WD-1:0]     dst_hrdata;

  always #5 clk = ~clk;

  assign src_hready = src_hready_resp;

  ahbl_arbiter #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
    .clk             (clk),
    .rst             (rst),
    .src_hready      (src_hready),
    .src_hready_resp (src_hready_resp),
    .src_hresp       (src_hresp),
    .src_haddr       (src_haddr),
    .src_hwrite      (src_hwrite),
    .src_htrans      (src_htrans),
    .src_hsize       (src_hsize),
    .src_hburst      (src_hburst),
    .src_hprot       (src_hprot),
    .src_hmastlock   (src_hmastlock),
    .src_hwdata      (src_hwdata),
    .src_hrdata      (src_hrdata),
    .dst_hready      (dst_hready),
    .dst_hready_resp (dst_hready_resp),
    .dst_hresp       (dst_hresp),
    .dst_haddr       (dst_haddr),
    .dst_hwrite      (dst_hwrite),
    .dst_htrans      (dst_htrans),
    .dst_hsize       (dst_hsize),
    .dst_hburst      (dst_hburst),
    .dst_hprot       (dst_hprot),
    .dst_hmastlock   (dst_hmastlock),
    .dst_hwdata      (dst_hwdata),
    .dst_hrdata      (dst_hrdata)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_m(input int m, input logic [1:0] trans, input logic [31:0] addr, input logic wr);
    src_htrans[2*m +: 2]  = trans;
    src_haddr[WA*m +: WA] = addr;
    src_hwrite[m]         = wr;
  endtask

  initial begin
    rst             = 1'b1;
    src_haddr       = '0;
    src_hwrite      = '0;
    src_htrans      = '0;
    src_hsize       = {3'd2, 3'd2};
    src_hburst      = '0;
    src_hprot       = {4'hA, 4'h3};
    src_hmastlock   = '0;
    src_hwdata      = '0;
    dst_hready_resp = 1'b1;
    dst_hresp       = 1'b0;
    dst_hrdata      = '0;
    repeat (2) @(posedge clk);

    // reset state
    @(negedge clk); rst = 1'b0; #1;
    check("rst_hready_resp", src_hready_resp, 2'b11);
    check("rst_hresp", src_hresp, 2'b00);
    check("rst_dst_htrans", dst_htrans, 2'b00);
    check("rst_dst_hready", dst_hready, 1'b1);

    // single master 0 read
    @(negedge clk); set_m(0, 2'b10, 32'h1000, 1'b0); #1;
    check("t1_htrans", dst_htrans, 2'b10);
    check("t1_haddr", dst_haddr, 32'h1000);
    check("t1_hsize", dst_hsize, 3'd2);
    check("t1_hready_resp_a", src_hready_resp, 2'b11);
    @(negedge clk); set_m(0, 2'b00, 32'h0, 1'b0); dst_hrdata = 32'hCAFE0001; #1;
    check("t1_hrdata0", src_hrdata[31:0], 32'hCAFE0001);
    check("t1_hready_resp_d", src_hready_resp, 2'b11);
    check("t1_idle", dst_htrans, 2'b00);

    // simultaneous requests: master 1 parked
    @(negedge clk); set_m(0, 2'b10, 32'h1000, 1'b0); set_m(1, 2'b10, 32'h2000, 1'b0); #1;
    check("t2_haddr_a", dst_haddr, 32'h1000);
    check("t2_prot_a", dst_hprot, 4'h3);
    check("t2_hready_resp_a", src_hready_resp, 2'b11);
    @(negedge clk); set_m(0, 2'b00, 32'h0, 1'b0); set_m(1, 2'b00, 32'h0, 1'b0); dst_hrdata = 32'h0BAD0002; #1;
    check("t2_hready_resp_b", src_hready_resp, 2'b01);
    check("t2_haddr_b", dst_haddr, 32'h2000);
    check("t2_htrans_b", dst_htrans, 2'b10);
    check("t2_prot_b", dst_hprot, 4'hA);
    @(negedge clk); dst_hrdata = 32'h5EED0003; #1;
    check("t2_hready_resp_c", src_hready_resp, 2'b11);
    check("t2_idle_c", dst_htrans, 2'b00);
    check("t2_hrdata1", src_hrdata[63:32], 32'h5EED0003);

    // master 1 parked across three downstream wait states
    @(negedge clk); set_m(0, 2'b10, 32'h1000, 1'b0); set_m(1, 2'b10, 32'h2000, 1'b0); #1;
    check("t3_haddr_a", dst_haddr, 32'h1000);
    @(negedge clk); set_m(0, 2'b00, 32'h0, 1'b0); set_m(1, 2'b00, 32'h0, 1'b0); dst_hready_resp = 1'b0; #1;
    check("t3_dst_hready_w", dst_hready, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k != 0) begin
        @(negedge clk); #1;
      end
      check("t3_hready_resp_w", src_hready_resp, 2'b00);
      check("t3_haddr_w", dst_haddr, 32'h2000);
    end
    @(negedge clk); dst_hready_resp = 1'b1; #1;
    check("t3_hready_resp_e", src_hready_resp, 2'b01);
    check("t3_haddr_e", dst_haddr, 32'h2000);
    check("t3_htrans_e", dst_htrans, 2'b10);
    @(negedge clk); #1;
    check("t3_hready_resp_f", src_hready_resp, 2'b11);
    check("t3_idle_f", dst_htrans, 2'b00);

    // two-cycle ERROR to master 1
    @(negedge clk); set_m(1, 2'b10, 32'h3000, 1'b0); #1;
    check("t4_haddr_a", dst_haddr, 32'h3000);
    @(negedge clk); set_m(1, 2'b00, 32'h0, 1'b0); dst_hready_resp = 1'b0; dst_hresp = 1'b1; #1;
    check("t4_hready_resp_e1", src_hready_resp, 2'b01);
    check("t4_hresp_e1", src_hresp, 2'b10);
    @(negedge clk); dst_hready_resp = 1'b1; #1;
    check("t4_hready_resp_e2", src_hready_resp, 2'b11);
    check("t4_hresp_e2", src_hresp, 2'b10);
    check("t4_no_reissue", dst_htrans, 2'b00);
    @(negedge clk); dst_hresp = 1'b0; #1;
    check("t4_hresp_after", src_hresp, 2'b00);

    // reset with both buffers valid
    @(negedge clk); set_m(0, 2'b10, 32'h5000, 1'b0); set_m(1, 2'b10, 32'h6000, 1'b0); dst_hready_resp = 1'b0; #1;
    check("t5_hready_resp_a", src_hready_resp, 2'b11);
    @(negedge clk); set_m(0, 2'b00, 32'h0, 1'b0); set_m(1, 2'b00, 32'h0, 1'b0); rst = 1'b1; #1;
    check("t5_both_parked", src_hready_resp, 2'b00);
    check("t5_htrans_parked", dst_htrans, 2'b10);
    check("t5_haddr_parked", dst_haddr, 32'h5000);
    @(negedge clk); rst = 1'b0; dst_hready_resp = 1'b1; #1;
    check("t5_hready_resp_r", src_hready_resp, 2'b11);
    check("t5_htrans_r", dst_htrans, 2'b00);
    check("t5_hresp_r", src_hresp, 2'b00);

    // back-to-back writes, write data aligned to data phase
    @(negedge clk); set_m(0, 2'b10, 32'hA000, 1'b1); set_m(1, 2'b10, 32'hB000, 1'b1); #1;
    check("t6_hwrite_a", dst_hwrite, 1'b1);
    check("t6_haddr_a", dst_haddr, 32'hA000);
    check("t6_hwdata_a", dst_hwdata, 32'h0);
    @(negedge clk); set_m(0, 2'b00, 32'h0, 1'b0); set_m(1, 2'b00, 32'h0, 1'b0);
    src_hwdata = {32'h22222222, 32'h11111111}; #1;
    check("t6_hwdata_b", dst_hwdata, 32'h11111111);
    check("t6_haddr_b", dst_haddr, 32'hB000);
    check("t6_hwrite_b", dst_hwrite, 1'b1);
    @(negedge clk); #1;
    check("t6_hwdata_c", dst_hwdata, 32'h22222222);
    check("t6_hready_resp_c", src_hready_resp, 2'b11);
    @(negedge clk); #1;
    check("t6_hwdata_d", dst_hwdata, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
